// File: rtl/warmup_sequencer_pkg.sv
// Shared definitions for the heater warm-up sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package warmup_sequencer_pkg;

  // 3-bit state codes, also exported on the STATE debug port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR_H = 3'd1,
    ST_HEAT  = 3'd2,
    ST_CLR_S = 3'd3,
    ST_SOAK  = 3'd4,
    ST_RDY   = 3'd5,
    ST_FLT   = 3'd6
  } state_e;

  // Cycles the counter reset is held low on each timer restart.
  localparam int unsigned CLR_CYCLES_DEF = 2;

  // The counter strobes are active low.
  localparam logic TIMER_ASSERT = 1'b0;
  localparam logic TIMER_IDLE   = 1'b1;

endpackage

// File: rtl/warmup_sequencer_sync2.sv
// Two-flop synchroniser for one asynchronous level input.
// Latency: 2 clk cycles from input edge to q.
// Backpressure: none; samples every cycle.
module warmup_sequencer_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the sample one stage per clock.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/warmup_sequencer.sv
// Heater warm-up sequencer: heat until TEMPOK, soak SOAK_TIME seconds, then READY.
// Latency: outputs registered; TEMPOK acts 3 cycles after its edge (2 sync + 1 FSM).
// Backpressure: none; REQ low aborts to IDLE from any state on the next edge.
module warmup_sequencer
  import warmup_sequencer_pkg::*;
#(
  parameter logic [15:0] HEAT_TIMEOUT = 16'd600,
  parameter logic [15:0] SOAK_TIME    = 16'd30,
  parameter int unsigned CLR_CYCLES   = CLR_CYCLES_DEF
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        TEMPOK,
  input  logic [15:0] TIMEELAPSED,
  input  logic        OVFL,
  output logic        TIMER_nSTART,
  output logic        TIMER_nRESET,
  output logic        HEATER_EN,
  output logic        READY,
  output logic        FAULT,
  output logic [2:0]  STATE
);

  localparam int unsigned PW = $clog2(CLR_CYCLES + 1);
  // Last restart phase: the single cycle that releases reset and pulses start.
  localparam logic [PW-1:0] PH_LAST = PW'(CLR_CYCLES);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          nstart_q, nstart_d;
  logic          nreset_q, nreset_d;
  logic          heater_q, heater_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          tok_s;
  logic          heat_expired;
  logic          soak_done;

  warmup_sequencer_sync2 u_tok_sync (
    .clk (MCLK),
    .rst (RESET),
    .d   (TEMPOK),
    .q   (tok_s)
  );

  // The timer reads 0 throughout a restart, so these never fire on stale counts.
  assign heat_expired = (TIMEELAPSED >= HEAT_TIMEOUT);
  assign soak_done    = (TIMEELAPSED >= SOAK_TIME);

  // Next-state: REQ low always wins, then the per-state priority order.
  always_comb begin
    state_d = state_q;
    phase_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (REQ) state_d = ST_CLR_H;
      end
      ST_CLR_H, ST_CLR_S: begin
        if (!REQ) begin
          state_d = ST_IDLE;
        end else if (phase_q == PH_LAST) begin
          state_d = (state_q == ST_CLR_H) ? ST_HEAT : ST_SOAK;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_HEAT: begin
        if (!REQ)                      state_d = ST_IDLE;
        else if (OVFL || heat_expired) state_d = ST_FLT;
        else if (tok_s)                state_d = ST_CLR_S;
      end
      ST_SOAK: begin
        if (!REQ)           state_d = ST_IDLE;
        else if (!tok_s)    state_d = ST_CLR_H;
        else if (soak_done) state_d = ST_RDY;
        else if (OVFL)      state_d = ST_FLT;
      end
      ST_RDY: begin
        if (!REQ)        state_d = ST_IDLE;
        else if (!tok_s) state_d = ST_CLR_H;
      end
      ST_FLT: begin
        if (!REQ) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output flop changes with STATE.
  always_comb begin
    nstart_d = TIMER_IDLE;
    nreset_d = TIMER_ASSERT;
    heater_d = 1'b0;
    ready_d  = 1'b0;
    fault_d  = 1'b0;
    unique case (state_d)
      ST_CLR_H, ST_CLR_S: begin
        heater_d = 1'b1;
        if (phase_d == PH_LAST) begin
          nreset_d = TIMER_IDLE;
          nstart_d = TIMER_ASSERT;
        end
      end
      ST_HEAT, ST_SOAK: begin
        heater_d = 1'b1;
        nreset_d = TIMER_IDLE;
      end
      ST_RDY: begin
        heater_d = 1'b1;
        ready_d  = 1'b1;
        nreset_d = TIMER_IDLE;
      end
      ST_FLT: begin
        fault_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, restart phase and registered outputs.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      nstart_q <= TIMER_IDLE;
      nreset_q <= TIMER_ASSERT;
      heater_q <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      nstart_q <= nstart_d;
      nreset_q <= nreset_d;
      heater_q <= heater_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  assign TIMER_nSTART = nstart_q;
  assign TIMER_nRESET = nreset_q;
  assign HEATER_EN    = heater_q;
  assign READY        = ready_q;
  assign FAULT        = fault_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_warmup_sequencer.sv
// Bench for warmup_sequencer with a behavioural seconds counter (1 s = 100 MCLK).
// Latency: n/a.
// Backpressure: n/a.
module tb_warmup_sequencer;

  localparam int          SEC_CYC = 100;
  localparam logic [15:0] HEAT_TO = 16'd600;
  localparam logic [15:0] SOAK_T  = 16'd30;
  localparam int          CLR_N   = 2;

  localparam logic [2:0] S_IDLE = 3'd0, S_CLR_H = 3'd1, S_HEAT = 3'd2, S_CLR_S = 3'd3,
                         S_SOAK = 3'd4, S_RDY = 3'd5, S_FLT = 3'd6;

  // Abstract model modes: a restart is one mode carrying its target.
  localparam int M_IDLE = 0, M_RST = 1, M_HEAT = 2, M_SOAK = 3, M_RDY = 4, M_FLT = 5;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ = 1'b0;
  logic        TEMPOK = 1'b0;
  logic        OVFL = 1'b0;
  logic [15:0] TIMEELAPSED = 16'd0;
  logic        TIMER_nSTART, TIMER_nRESET, HEATER_EN, READY, FAULT;
  logic [2:0]  STATE;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 MCLK = ~MCLK;

  warmup_sequencer #(
    .HEAT_TIMEOUT (HEAT_TO),
    .SOAK_TIME    (SOAK_T),
    .CLR_CYCLES   (CLR_N)
  ) dut (
    .MCLK         (MCLK),
    .RESET        (RESET),
    .REQ          (REQ),
    .TEMPOK       (TEMPOK),
    .TIMEELAPSED  (TIMEELAPSED),
    .OVFL         (OVFL),
    .TIMER_nSTART (TIMER_nSTART),
    .TIMER_nRESET (TIMER_nRESET),
    .HEATER_EN    (HEATER_EN),
    .READY        (READY),
    .FAULT        (FAULT),
    .STATE        (STATE)
  );

  // Behavioural elapsed-seconds counter driven by the DUT strobes.
  int   sub_cnt = 0;
  logic running = 1'b0;
  always @(posedge MCLK) begin
    if (!TIMER_nRESET) begin
      TIMEELAPSED <= 16'd0; sub_cnt <= 0; running <= 1'b0;
    end else if (!TIMER_nSTART) begin
      TIMEELAPSED <= 16'd0; sub_cnt <= 0; running <= 1'b1;
    end else if (running) begin
      if (sub_cnt == SEC_CYC - 1) begin
        sub_cnt <= 0; TIMEELAPSED <= TIMEELAPSED + 16'd1;
      end else begin
        sub_cnt <= sub_cnt + 1;
      end
    end
  end

  // Reference model of the sequencing rules.
  int   m_mode = M_IDLE;
  int   m_tgt = M_HEAT;
  int   m_left = 0;
  logic m_t1 = 1'b0, m_t2 = 1'b0;

  always @(posedge MCLK) begin
    if (RESET) begin
      m_mode <= M_IDLE; m_t1 <= 1'b0; m_t2 <= 1'b0;
    end else begin
      m_t1 <= TEMPOK;
      m_t2 <= m_t1;
      if (!REQ) begin
        m_mode <= M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE: begin m_mode <= M_RST; m_tgt <= M_HEAT; m_left <= CLR_N + 1; end
          M_RST: begin
            if (m_left == 1) m_mode <= m_tgt;
            else m_left <= m_left - 1;
          end
          M_HEAT: begin
            if (OVFL || TIMEELAPSED >= HEAT_TO) m_mode <= M_FLT;
            else if (m_t2) begin m_mode <= M_RST; m_tgt <= M_SOAK; m_left <= CLR_N + 1; end
          end
          M_SOAK: begin
            if (!m_t2) begin m_mode <= M_RST; m_tgt <= M_HEAT; m_left <= CLR_N + 1; end
            else if (TIMEELAPSED >= SOAK_T) m_mode <= M_RDY;
            else if (OVFL) m_mode <= M_FLT;
          end
          M_RDY: begin
            if (!m_t2) begin m_mode <= M_RST; m_tgt <= M_HEAT; m_left <= CLR_N + 1; end
          end
          default: ;
        endcase
      end
    end
  end

  // Expected {STATE, nSTART, nRESET, HEATER_EN, READY, FAULT} for a model mode.
  function automatic logic [7:0] expect_out(input int mode, input int tgt, input int left);
    logic [2:0] st;
    logic ns, nr, ht, rd, ft;
    st = S_IDLE; ns = 1'b1; nr = 1'b0; ht = 1'b0; rd = 1'b0; ft = 1'b0;
    case (mode)
      M_RST: begin
        st = (tgt == M_HEAT) ? S_CLR_H : S_CLR_S;
        ht = 1'b1;
        if (left == 1) begin ns = 1'b0; nr = 1'b1; end
      end
      M_HEAT: begin st = S_HEAT; ht = 1'b1; nr = 1'b1; end
      M_SOAK: begin st = S_SOAK; ht = 1'b1; nr = 1'b1; end
      M_RDY:  begin st = S_RDY;  ht = 1'b1; nr = 1'b1; rd = 1'b1; end
      M_FLT:  begin st = S_FLT;  ft = 1'b1; end
      default: ;
    endcase
    return {st, ns, nr, ht, rd, ft};
  endfunction

  // Per-cycle comparison against the model; stops after ten mismatches.
  always @(negedge MCLK) begin
    logic [7:0] act_v, exp_v;
    if (chk_en && failures < 10) begin
      exp_v = expect_out(m_mode, m_tgt, m_left);
      act_v = {STATE, TIMER_nSTART, TIMER_nRESET, HEATER_EN, READY, FAULT};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model_cmp t=%0t: got state=%0d ns/nr/ht/rd/ft=%b expected state=%0d ns/nr/ht/rd/ft=%b",
                 $time, act_v[7:5], act_v[4:0], exp_v[7:5], exp_v[4:0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  // Cycles until STATE==s (-1 on timeout), counting nSTART-low cycles seen.
  task automatic wait_state(input logic [2:0] s, input int max, output int n, output int nst_low);
    n = 0; nst_low = 0;
    while (STATE !== s) begin
      if (n >= max) begin n = -1; return; end
      @(negedge MCLK);
      n++;
      if (TIMER_nSTART === 1'b0) nst_low++;
    end
  endtask

  task automatic wait_te(input logic [15:0] v, input int max, input string name);
    int n;
    n = 0;
    while (TIMEELAPSED !== v && n < max) begin
      @(negedge MCLK);
      n++;
    end
    chk(name, (TIMEELAPSED === v) ? 1 : 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ns;
    tick(3);
    chk_en = 1'b1;
    chk("rst_state", STATE, S_IDLE);
    chk("rst_nreset", TIMER_nRESET, 0);
    chk("rst_nstart", TIMER_nSTART, 1);
    chk("rst_heater", HEATER_EN, 0);
    chk("rst_ready", READY, 0);
    chk("rst_fault", FAULT, 0);
    RESET = 1'b0;
    tick(2);

    // Nominal warm-up.
    REQ = 1'b1;
    wait_state(S_HEAT, 20, n, ns);
    chk("t1_req_to_heat", n, 4);
    chk("t1_clrh_nstart_pulses", ns, 1);
    chk("t1_heater_on", HEATER_EN, 1);
    wait_te(16'd5, 700, "t1_reach_5s");
    TEMPOK = 1'b1;
    wait_state(S_CLR_S, 10, n, ns);
    chk("t1_tok_to_clrs", n, 3);
    wait_state(S_SOAK, 10, n, ns);
    chk("t1_clrs_len", n, 3);
    chk("t1_clrs_nstart_pulses", ns, 1);
    wait_state(S_RDY, 4000, n, ns);
    chk("t1_soak_to_ready", n, 3001);
    chk("t1_ready", READY, 1);

    // Ready loss.
    TEMPOK = 1'b0;
    wait_state(S_CLR_H, 10, n, ns);
    chk("t4_tok_drop_to_clrh", n, 3);
    chk("t4_ready_low", READY, 0);
    chk("t4_heater_still_on", HEATER_EN, 1);

    // Soak dropout and retry.
    wait_state(S_HEAT, 10, n, ns);
    chk("t3_clrh_to_heat", n, 3);
    wait_te(16'd2, 300, "t3_reach_2s");
    TEMPOK = 1'b1;
    wait_state(S_SOAK, 20, n, ns);
    chk("t3_tok_to_soak", n, 6);
    wait_te(16'd10, 1100, "t3_soak_10s");
    TEMPOK = 1'b0;
    wait_state(S_CLR_H, 10, n, ns);
    chk("t3_dropout_to_clrh", n, 3);
    tick(1);
    chk("t3_timer_rezeroed", TIMEELAPSED, 0);
    wait_state(S_HEAT, 10, n, ns);
    chk("t3_rest_of_clrh", n, 2);
    wait_te(16'd3, 400, "t3_reheat_3s");
    TEMPOK = 1'b1;
    wait_state(S_SOAK, 20, n, ns);
    chk("t3_retry_tok_to_soak", n, 6);
    wait_state(S_RDY, 4000, n, ns);
    chk("t3_full_soak_again", n, 3001);

    // Overflow in SOAK.
    REQ = 1'b0;
    wait_state(S_IDLE, 5, n, ns);
    chk("t5_req_low_to_idle", n, 1);
    REQ = 1'b1;
    wait_state(S_SOAK, 20, n, ns);
    chk("t5_idle_to_soak", n, 8);
    chk("t5_two_nstart_pulses", ns, 2);
    tick(50);
    OVFL = 1'b1;
    wait_state(S_FLT, 5, n, ns);
    chk("t5_ovfl_to_flt", n, 1);
    chk("t5_fault", FAULT, 1);
    chk("t5_heater_off", HEATER_EN, 0);
    chk("t5_nreset_low", TIMER_nRESET, 0);
    OVFL = 1'b0;
    REQ = 1'b0;
    wait_state(S_IDLE, 5, n, ns);
    chk("t5_flt_exit", n, 1);
    chk("t5_fault_clear", FAULT, 0);

    // Reset mid-SOAK, then abort during CLR_H.
    REQ = 1'b1;
    wait_state(S_SOAK, 20, n, ns);
    chk("t6_idle_to_soak", n, 8);
    tick(20);
    RESET = 1'b1;
    tick(1);
    chk("t6_rst_state", STATE, S_IDLE);
    chk("t6_rst_nreset", TIMER_nRESET, 0);
    chk("t6_rst_nstart", TIMER_nSTART, 1);
    chk("t6_rst_heater", HEATER_EN, 0);
    chk("t6_rst_ready", READY, 0);
    chk("t6_rst_fault", FAULT, 0);
    RESET = 1'b0;
    wait_state(S_CLR_H, 5, n, ns);
    chk("t6_idle_to_clrh", n, 1);
    REQ = 1'b0;
    wait_state(S_IDLE, 5, n, ns);
    chk("t6_abort_to_idle", n, 1);
    chk("t6_abort_no_nstart", ns, 0);
    tick(5);
    chk("t6_idle_nreset_low", TIMER_nRESET, 0);

    // Heat timeout.
    TEMPOK = 1'b0;
    tick(3);
    REQ = 1'b1;
    wait_state(S_FLT, 61000, n, ns);
    chk("t2_req_to_flt", n, 60005);
    chk("t2_elapsed_at_flt", TIMEELAPSED, 600);
    chk("t2_fault", FAULT, 1);
    chk("t2_heater_off", HEATER_EN, 0);
    REQ = 1'b0;
    wait_state(S_IDLE, 5, n, ns);
    chk("t2_flt_exit", n, 1);
    chk("t2_fault_clear", FAULT, 0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
